// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: fully registered valid/ready slice (main + skid entry), ready path registered too.
// Optional saturating stall counter with stall_clr/stall_cnt ports under `PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
    parameter int DW = 16
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    input  logic             stall_clr,
    output logic [CNT_W-1:0] stall_cnt
`endif
);
    // Encoding is {main_vld, skid_vld}; 2'b01 is unreachable
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
    state_t        state, state_nxt;
    logic [DW-1:0] main_data, skid_data, main_nxt, skid_nxt;
    logic          in_fire, out_fire;
    assign out_vld  = state[1];
    assign in_rdy   = ~state[0];
    assign out_data = main_data;
    assign in_fire  = in_vld & in_rdy;
    assign out_fire = out_vld & out_rdy;
    always_comb begin
        state_nxt = state;
        main_nxt  = main_data;
        skid_nxt  = skid_data;
        case (state)
            EMPTY: if (in_fire) begin
                main_nxt  = in_data;
                state_nxt = ONE;
            end
            ONE: if (in_fire & out_fire) main_nxt = in_data;
            else if (in_fire) begin
                skid_nxt  = in_data;
                state_nxt = FULL;
            end
            else if (out_fire) state_nxt = EMPTY;
            FULL: if (out_fire) begin
                main_nxt  = skid_data;
                state_nxt = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            main_data <= main_nxt;
            skid_data <= skid_nxt;
        end
    end
`ifdef PIPE_SKID_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else if (stall_clr) stall_cnt <= '0;
        else if (out_vld & ~out_rdy & ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed checks of the skid slice plus a scoreboarded random phase.
module tb_pipe_skid_stage;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_vld = 0;
    logic        in_rdy;
    logic [15:0] in_data = '0;
    logic        out_vld;
    logic        out_rdy = 0;
    logic [15:0] out_data;
    int          vectors = 0;
    int          errs = 0;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic        stall_clr = 0;
    logic [3:0]  stall_cnt;
    pipe_skid_stage #(.DW(16), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .stall_clr(stall_clr), .stall_cnt(stall_cnt));
`else
    pipe_skid_stage #(.DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data));
`endif
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] q[$];
    logic [15:0] held;
    logic        stalled;

    initial begin
        tick();
        tick();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_rdy", in_rdy, 1);
        rst_n = 1;
        tick();
        out_rdy = 1;
        for (int i = 1; i <= 8; i++) begin
            in_vld  = 1;
            in_data = 16'(i);
            chk("stream_in_rdy", in_rdy, 1);
            tick();
            chk("stream_out_vld", out_vld, 1);
            chk("stream_out_data", out_data, i);
        end
        in_vld = 0;
        tick();
        chk("stream_end_vld", out_vld, 0);
        out_rdy = 0;
        in_vld  = 1;
        in_data = 16'hAAAA;
        tick();
        chk("bp_a_data", out_data, 16'hAAAA);
        chk("bp_a_rdy", in_rdy, 1);
        in_data = 16'hBBBB;
        tick();
        chk("bp_b_rdy", in_rdy, 0);
        chk("bp_b_data", out_data, 16'hAAAA);
        in_data = 16'hCCCC;
        tick();
        chk("bp_c_rdy", in_rdy, 0);
        chk("bp_c_hold", out_data, 16'hAAAA);
        out_rdy = 1;
        tick();
        chk("rec_b_data", out_data, 16'hBBBB);
        chk("rec_b_vld", out_vld, 1);
        chk("rec_rdy", in_rdy, 1);
        tick();
        chk("rec_c_data", out_data, 16'hCCCC);
        in_vld = 0;
        tick();
        chk("rec_empty", out_vld, 0);
        out_rdy = 0;
        in_vld  = 1;
        in_data = 16'h1234;
        tick();
        in_vld = 0;
        chk("drain_vld", out_vld, 1);
        chk("drain_data", out_data, 16'h1234);
        out_rdy = 1;
        tick();
        out_rdy = 0;
        chk("drain_empty", out_vld, 0);
        chk("drain_hold", out_data, 16'h1234);
        tick();
        chk("drain_hold2", out_data, 16'h1234);
`ifdef PIPE_SKID_STALL_CNT_EN
        in_vld    = 1;
        in_data   = 16'h5555;
        stall_clr = 1;
        tick();
        in_vld    = 0;
        stall_clr = 0;
        chk("cnt_zero", stall_cnt, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("cnt_sat", stall_cnt, 15);
        stall_clr = 1;
        tick();
        stall_clr = 0;
        chk("cnt_clr", stall_cnt, 0);
        tick();
        chk("cnt_again", stall_cnt, 1);
        out_rdy = 1;
        tick();
        out_rdy = 0;
        chk("cnt_drain", out_vld, 0);
`endif
        in_vld  = 1;
        in_data = 16'h7777;
        tick();
        in_data = 16'h8888;
        tick();
        chk("mid_full", in_rdy, 0);
        rst_n = 0;
        #1;
        chk("mid_rst_vld", out_vld, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_rdy", in_rdy, 1);
        tick();
        rst_n   = 1;
        in_data = 16'h9999;
        chk("post_rst_vld", out_vld, 0);
        tick();
        chk("post_rst_first_vld", out_vld, 1);
        chk("post_rst_first_data", out_data, 16'h9999);
        in_vld  = 0;
        out_rdy = 1;
        tick();
        chk("post_rst_empty", out_vld, 0);
        for (int c = 0; c < 2000; c++) begin
            in_vld  = 1'($urandom_range(0, 1));
            out_rdy = 1'($urandom_range(0, 1));
            in_data = 16'($urandom);
            #1;
            stalled = out_vld & ~out_rdy;
            held    = out_data;
            if (out_vld & out_rdy) begin
                chk("rnd_not_empty", q.size() > 0, 1);
                if (q.size() > 0) chk("rnd_order", out_data, q.pop_front());
            end
            if (in_vld & in_rdy) q.push_back(in_data);
            tick();
            if (stalled) begin
                chk("rnd_stall_vld", out_vld, 1);
                chk("rnd_stall_data", out_data, held);
            end
        end
        in_vld  = 0;
        out_rdy = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_vld) begin
                chk("flush_not_empty", q.size() > 0, 1);
                if (q.size() > 0) chk("flush_order", out_data, q.pop_front());
            end
            tick();
        end
        chk("flush_q_empty", q.size(), 0);
        chk("flush_out_vld", out_vld, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
